// File: rtl/ahb_rr_master_arbiter_pkg.sv
// Shared types and defaults for the round-robin AHB master arbiter.
package ahb_rr_master_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int DEF_TIMEOUT    = 16;
    localparam int AHB_ADDR_WIDTH = 32;
    localparam int AHB_DATA_WIDTH = 32;

endpackage

// File: rtl/ahb_rr_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module ahb_rr_master_arbiter_rr_pick #(
    parameter  int N  = 2,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    logic [PW-1:0] w_k;

    // Scan from farthest to nearest so the requester closest to i_ptr wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_k      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_k = PW'((int'(i_ptr) + i) % N);
            if (i_req[w_k]) begin
                o_onehot      = '0;
                o_onehot[w_k] = 1'b1;
                o_idx         = w_k;
                o_any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_rr_master_arbiter.sv
// Round-robin arbiter sequencing one non-pipelined AHB transfer at a time
// (IDLE -> ADDR -> DATA) with a wait-state timeout on the DATA phase.
module ahb_rr_master_arbiter
    import ahb_rr_master_arbiter_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = AHB_ADDR_WIDTH,
    parameter int DATA_W  = AHB_DATA_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_MST-1:0]      req_i,
    input  logic [NUM_MST*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_MST*DATA_W-1:0] req_wdata_i,
    input  logic [NUM_MST-1:0]      req_write_i,
    output logic [NUM_MST-1:0]      gnt_o,
    output logic [NUM_MST-1:0]      done_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    err_o,
    output logic                    hsel,
    output logic [ADDR_W-1:0]       haddr_m2s,
    output logic [DATA_W-1:0]       hdata_m2s,
    output logic                    hwrite,
    input  logic                    hready,
    input  logic                    hresp,
    input  logic [DATA_W-1:0]       hrdata
);

    localparam int PW = $clog2(NUM_MST);
    localparam int CW = $clog2(TIMEOUT);

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_win;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;
    logic                r_dphase;
    logic [CW-1:0]       r_wait;

    logic [NUM_MST-1:0]  w_onehot;
    logic [PW-1:0]       w_idx;
    logic                w_any;
    logic [NUM_MST-1:0]  w_done_oh;
    logic [ADDR_W-1:0]   w_addr  [NUM_MST];
    logic [DATA_W-1:0]   w_wdata [NUM_MST];

    for (genvar k = 0; k < NUM_MST; k++) begin : g_unpack
        assign w_addr[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
        assign w_wdata[k] = req_wdata_i[k*DATA_W +: DATA_W];
    end

    assign w_done_oh = NUM_MST'(1) << r_win;

    ahb_rr_master_arbiter_rr_pick #(.N(NUM_MST)) u_pick (
        .i_req    (req_i),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_dphase  <= 1'b0;
            r_wait    <= '0;
            gnt_o     <= '0;
            done_o    <= '0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
            hsel      <= 1'b0;
            haddr_m2s <= '0;
            hdata_m2s <= '0;
            hwrite    <= 1'b0;
        end else begin
            gnt_o  <= '0;
            done_o <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        gnt_o   <= w_onehot;
                        r_win   <= w_idx;
                        r_addr  <= w_addr[w_idx];
                        r_wdata <= w_wdata[w_idx];
                        r_write <= req_write_i[w_idx];
                        r_ptr   <= (w_idx == PW'(NUM_MST - 1)) ? '0 : w_idx + PW'(1);
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    hsel      <= 1'b1;
                    haddr_m2s <= r_addr;
                    hwrite    <= r_write;
                    r_wait    <= '0;
                    r_dphase  <= 1'b0;
                    r_state   <= ST_DATA;
                end
                ST_DATA: begin
                    hdata_m2s <= r_write ? r_wdata : '0;
                    r_dphase  <= 1'b1;
                    // First DATA edge only launches write data; hready is sampled from the next edge on.
                    if (r_dphase) begin
                        if (hready) begin
                            done_o  <= w_done_oh;
                            err_o   <= hresp;
                            rdata_o <= r_write ? '0 : hrdata;
                            hsel    <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (r_wait == CW'(TIMEOUT - 1)) begin
                            done_o  <= w_done_oh;
                            err_o   <= 1'b1;
                            rdata_o <= '0;
                            hsel    <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_wait <= r_wait + CW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
